// File: rtl/decode_stage.sv
// RV32I decode stage: splits instructions into fields and immediates,
// registered toward execute behind a two-entry skid buffer.
module decode_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [31:0]       insn_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [31:0]       insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic              illegal_o
);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [31:0]       insn;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DWIDTH-1:0] imm;
    logic              illegal;
  } bundle_t;

  logic               r_out_valid;
  logic               r_skid_valid;
  bundle_t            r_out;
  bundle_t            r_skid;
  bundle_t            w_dec;
  logic               w_accept;
  logic [6:0]         w_op;
  logic signed [31:0] w_imm32;
  logic               w_ill;
  logic               w_f7_en;

  assign w_op     = insn_i[6:0];
  assign w_accept = valid_i && ready_o;

  always_comb begin
    w_imm32 = '0;
    w_ill   = 1'b0;
    w_f7_en = 1'b0;
    unique case (w_op)
      7'h03, 7'h67, 7'h73:
        w_imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
      7'h13: begin
        w_imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
        w_f7_en = (insn_i[13:12] == 2'b01);
      end
      7'h23:
        w_imm32 = {{20{insn_i[31]}}, insn_i[31:25],
                   insn_i[11:7]};
      7'h63:
        w_imm32 = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                   insn_i[30:25], insn_i[11:8], 1'b0};
      7'h37, 7'h17:
        w_imm32 = {insn_i[31:12], 12'b0};
      7'h6F:
        w_imm32 = {{11{insn_i[31]}}, insn_i[31],
                   insn_i[19:12], insn_i[20],
                   insn_i[30:21], 1'b0};
      7'h33:
        w_f7_en = 1'b1;
      default:
        w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = pc_i;
    w_dec.insn    = insn_i;
    w_dec.opcode  = w_op;
    w_dec.rd      = insn_i[11:7];
    w_dec.rs1     = insn_i[19:15];
    w_dec.rs2     = insn_i[24:20];
    w_dec.funct3  = insn_i[14:12];
    w_dec.funct7  = w_f7_en ? insn_i[31:25] : 7'd0;
    w_dec.imm     = DWIDTH'(w_imm32);
    w_dec.illegal = w_ill;
  end

  // Output slot refills from the skid first so order is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || ready_i) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign ready_o   = !r_skid_valid;
  assign valid_o   = r_out_valid;
  assign pc_o      = r_out.pc;
  assign insn_o    = r_out.insn;
  assign opcode_o  = r_out.opcode;
  assign rd_o      = r_out.rd;
  assign rs1_o     = r_out.rs1;
  assign rs2_o     = r_out.rs2;
  assign funct3_o  = r_out.funct3;
  assign funct7_o  = r_out.funct7;
  assign imm_o     = r_out.imm;
  assign illegal_o = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver queues expected bundles,
// monitor pops and compares on every delivered entry.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] insn_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic        illegal_o;

  decode_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .insn_i(insn_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o),
    .imm_o(imm_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  bit   acc_now = 1'b0;
  bit   rst_seen = 1'b0;

  logic [6:0] legal_ops [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23,
                                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  function automatic exp_t model(logic [31:0] pc, logic [31:0] insn);
    exp_t e;
    logic signed [31:0] s;
    logic [6:0] op;
    op = insn[6:0];
    e.pc = pc;
    e.insn = insn;
    e.opcode = op;
    e.rd = insn[11:7];
    e.rs1 = insn[19:15];
    e.rs2 = insn[24:20];
    e.f3 = insn[14:12];
    e.f7 = 7'd0;
    e.imm = 32'd0;
    e.ill = 1'b0;
    if (op == 7'h33 ||
        (op == 7'h13 && (e.f3 == 3'd1 || e.f3 == 3'd5)))
      e.f7 = insn[31:25];
    case (op)
      7'h03, 7'h13, 7'h67, 7'h73: begin
        s = {insn[31:20], 20'h0};
        e.imm = s >>> 20;
      end
      7'h23: begin
        s = {insn[31:25], insn[11:7], 20'h0};
        e.imm = s >>> 20;
      end
      7'h63: begin
        s = {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0, 19'h0};
        e.imm = s >>> 19;
      end
      7'h6F: begin
        s = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0, 11'h0};
        e.imm = s >>> 11;
      end
      7'h37, 7'h17: e.imm = insn & 32'hFFFF_F000;
      7'h33: e.imm = 32'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] pc,
                      input logic [31:0] insn, input bit rdy,
                      input bit fl, output bit acc);
    @(posedge clk);
    #1;
    valid_i = v;
    pc_i = pc;
    insn_i = insn;
    ready_i = rdy;
    flush_i = fl;
    acc_now = 1'b0;
    @(negedge clk);
    acc = v && ready_o && !fl;
    if (fl) q.delete();
    else if (acc) q.push_back(model(pc, insn));
    acc_now = acc;
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] insn,
                     input bit rdy);
    bit a;
    a = 1'b0;
    for (int k = 0; k < 40 && !a; k++) step(1'b1, pc, insn, rdy, 1'b0, a);
    chk("put_accept_timeout", 64'(a), 64'd1);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    valid_i = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_imm_o", 64'(imm_o), 64'd0);
    q.delete();
    acc_now = 1'b0;
    rst_seen = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  // Monitor: occupancy, handshake values, stall stability, scoreboard.
  initial begin
    exp_t cur, prev, e;
    bit   have_prev;
    int   occ;
    have_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (rst_seen) begin
          have_prev = 1'b0;
          rst_seen = 1'b0;
        end
        occ = int'(q.size()) - int'(acc_now);
        cur = {pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
               funct3_o, funct7_o, imm_o, illegal_o};
        if (!flush_i) begin
          chk("ready_o", 64'(ready_o), 64'(occ < 2));
          chk("valid_o", 64'(valid_o), 64'(occ > 0));
        end
        if (have_prev) begin
          chk("stall_valid", 64'(valid_o), 64'd1);
          chk("stall_pc", 64'(cur.pc), 64'(prev.pc));
          chk("stall_bundle_imm", 64'(cur.imm), 64'(prev.imm));
        end
        if (valid_o && ready_i && !flush_i) begin
          n_chk++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: pc %h insn %h", pc_o, insn_o);
          end else begin
            e = q.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL bundle: got pc %h insn %h rd %h rs1 %h rs2 %h f3 %h f7 %h imm %h ill %b want pc %h insn %h rd %h rs1 %h rs2 %h f3 %h f7 %h imm %h ill %b",
                       cur.pc, cur.insn, cur.rd, cur.rs1, cur.rs2, cur.f3,
                       cur.f7, cur.imm, cur.ill, e.pc, e.insn, e.rd, e.rs1,
                       e.rs2, e.f3, e.f7, e.imm, e.ill);
            end
          end
        end
        have_prev = valid_o && !ready_i && !flush_i;
        prev = cur;
      end
    end
  end

  // Driver
  initial begin
    bit a;
    bit pend;
    bit v;
    bit rdy;
    bit fl;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] stream [7] = '{32'hFFF00093, 32'h123452B7, 32'hFE000CE3,
                                32'h402081B3, 32'h4020D093, 32'h40008093,
                                32'h0000007F};
    #2;
    chk("init_valid_o", 64'(valid_o), 64'd0);
    chk("init_ready_o", 64'(ready_o), 64'd1);
    chk("init_imm_o", 64'(imm_o), 64'd0);
    chk("init_pc_o", 64'(pc_o), 64'd0);
    #10;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) put(32'h100 + 32'(i * 4), stream[i], 1'b1);
    idle(3);

    put(32'h200, 32'h00108093, 1'b0);
    put(32'h204, 32'h00210113, 1'b0);
    step(1'b1, 32'h208, 32'h00318193, 1'b0, 1'b0, a);
    chk("bp_c_held", 64'(a), 64'd0);
    step(1'b1, 32'h208, 32'h00318193, 1'b0, 1'b0, a);
    chk("bp_c_held2", 64'(a), 64'd0);
    put(32'h208, 32'h00318193, 1'b1);
    idle(4);

    put(32'h300, 32'hFFF00093, 1'b0);
    put(32'h304, 32'h123452B7, 1'b0);
    step(1'b1, 32'h308, 32'hDEADB0B7, 1'b0, 1'b1, a);
    idle(4);

    put(32'h400, 32'hFFF00093, 1'b0);
    put(32'h404, 32'hFE000CE3, 1'b0);
    pulse_reset();
    put(32'h500, 32'h0000007F, 1'b1);
    idle(3);

    pend = 1'b0;
    pc = 32'h1000;
    insn = '0;
    v = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        pc = pc + 32'd4;
        insn = $urandom;
        if ($urandom_range(3) != 0)
          insn[6:0] = legal_ops[$urandom_range(9)];
        v = ($urandom_range(3) != 0);
      end
      fl = ($urandom_range(49) == 0);
      rdy = fl ? 1'b0 : ($urandom_range(2) != 0);
      step(v, pc, insn, rdy, fl, a);
      pend = v && !a && !fl;
    end
    idle(6);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I decode stage: it is the producer side of the execute-stage interface. It accepts fetched instructions with their PC through a valid/ready handshake. It splits each instruction into register indices, funct3/funct7, and a sign-extended immediate, and presents them registered to execute. A two-entry skid buffer gives full throughput under back-pressure with a registered `ready_o`.

## Interface
- `DWIDTH`, 32, data/immediate width
- `AWIDTH`, 32, PC width

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `flush_i`  in  1  synchronous kill of all buffered entries
- `valid_i`  in  1  upstream (fetch) entry valid
- `ready_o`  out  1  stage can accept; reset 1
- `pc_i`  in  AWIDTH  PC of incoming instruction
- `insn_i`  in  32  incoming instruction
- `valid_o`  out  1  decoded entry valid; reset 0
- `ready_i`  in  1  execute can accept
- `pc_o`  out  AWIDTH  registered PC; reset 0
- `insn_o`  out  32  registered raw instruction; reset 0
- `opcode_o`  out  7  insn[6:0]; reset 0
- `rd_o`, `rs1_o`, `rs2_o`  out  5 each  insn[11:7], [19:15], [24:20]; reset 0
- `funct3_o`  out  3  insn[14:12]; reset 0
- `funct7_o`  out  7  qualified funct7 (see Operation); reset 0
- `imm_o`  out  DWIDTH  sign-extended immediate; reset 0
- `illegal_o`  out  1  opcode not in RV32I base set; reset 0

## Operation
- Immediate select by opcode:
  - I-type (0000011 load, 0010011 op-imm, 1100111 jalr, 1110011 system): sext(insn[31:20])
  - S-type (0100011): sext({insn[31:25], insn[11:7]})
  - B-type (1100011): sext({insn[31], insn[7], insn[30:25], insn[11:8], 0})
  - U-type (0110111 lui, 0010111 auipc): {insn[31:12], 12'b0}
  - J-type (1101111): sext({insn[31], insn[19:12], insn[20], insn[30:21], 0})
  - R-type (0110011) and illegal opcodes: 0
- funct7_o: insn[31:25] for opcode 0110011; for 0010011 with funct3 001/101, insn[31:25] (shift immediates, SRAI bit 30); otherwise 0. Execute then never sees SUB/SRA for ADDI/XORI etc.
- illegal_o = 1 for any opcode outside the ten listed above. The entry still flows; there is no trap here.
- Decode is combinational on the input. Results are captured into the output register or the skid register. Both hold the full decoded bundle.
- State: out_valid (drives `valid_o`) and skid_valid. `ready_o` = !skid_valid.
- accept = valid_i && ready_o.
- Each edge, in priority order:
  - reset: both valid bits 0, all bundles 0.
  - flush_i: both valid bits 0. Data is don't-care and accept is ignored.
  - !out_valid || ready_i: if skid_valid, output takes skid and skid_valid goes to 0. Else if accept, output takes the input. Else out_valid goes to 0.
  - out_valid && !ready_i && accept: skid takes the input and skid_valid goes to 1.
- Data does not change while valid_o && !ready_i (stable-under-stall).
- Order is preserved; no entry is dropped or duplicated.

## Timing
- Latency: 1 cycle from accept to `valid_o` when the stage is empty.
- Throughput: 1 instruction/cycle while `ready_i` = 1.
- `ready_o` is a register output. It falls the cycle after the skid fills and rises the cycle after the skid drains.
- Reset mid-stream: outputs go to their reset values immediately (async). The first accept is allowed on the first edge after deassert.
- Flush with simultaneous `valid_i`: the input is dropped. `valid_o` = 0 next cycle.
- Stall with `ready_o` = 0: upstream must hold; the stage ignores `valid_i`.

## Test plan
- Reset: assert `reset` mid-stream with both entries full → `valid_o` = 0, `ready_o` = 1, `imm_o` = 0 immediately.
- Immediates, stream back-to-back with `ready_i` = 1:
  - 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFFFFFF, funct7_o 0, rd 1
  - 0x123452B7 (lui) → imm 0x12345000
  - 0xFE000CE3 (beq -8) → imm 0xFFFFFFF8
  - one per cycle, latency 1
- funct7 qualification:
  - 0x402081B3 (sub x3,x1,x2) → funct7_o 0x20
  - 0x4020D093 (srai x1,x1,2) → funct7_o 0x20
  - 0x40008093 (addi x1,x1,0x400) → funct7_o 0
- Back-pressure: feed A,B,C with `ready_i` = 0 → `valid_o` holds A stable, B goes to skid, `ready_o` = 0 next cycle, C held. Release `ready_i` → A,B,C delivered in order, none lost.
- Flush: with both entries full and `valid_i` = 1, pulse `flush_i` → `valid_o` = 0, `ready_o` = 1 next cycle, and the input does not appear.
- Illegal: 0x0000007F → `illegal_o` = 1, imm 0, entry still delivered.
